// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the multiplier issue controller and its result FIFO.
package mult_ctrl_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int TAG_W_DEF      = 6;
    localparam int LATENCY_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
    } result_t;

    // A credit counter must be able to hold the value FIFO_DEPTH itself.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Issue-queue and CDB handshake bundle for mult_issue_ctrl; the flush wire exists only with MULT_FLUSH_EN.
interface mult_issue_ctrl_if
    import mult_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);

    logic              issuemult_enable;
    logic              issuemult_ready;
    logic [DATA_W-1:0] issuemult_rsdata;
    logic [DATA_W-1:0] issuemult_rtdata;
    logic [TAG_W-1:0]  issuemult_rdtag;
    logic              cdb_valid;
    logic              cdb_grant;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_rdtag;
`ifdef MULT_FLUSH_EN
    logic              flush;

    modport slave (
        input  issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
        input  cdb_grant, flush,
        output issuemult_ready, cdb_valid, cdb_data, cdb_rdtag
    );
    modport master (
        output issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
        output cdb_grant, flush,
        input  issuemult_ready, cdb_valid, cdb_data, cdb_rdtag
    );
`else
    modport slave (
        input  issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
        input  cdb_grant,
        output issuemult_ready, cdb_valid, cdb_data, cdb_rdtag
    );
    modport master (
        output issuemult_enable, issuemult_rsdata, issuemult_rtdata, issuemult_rdtag,
        output cdb_grant,
        input  issuemult_ready, cdb_valid, cdb_data, cdb_rdtag
    );
`endif

endinterface

// File: rtl/mult_result_fifo.sv
// Synchronous result FIFO with wrap-bit pointers; MULT_FLUSH_EN adds a single-cycle flush.
module mult_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULT_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             clear;
    logic             do_push;
    logic             do_pop;

`ifdef MULT_FLUSH_EN
    assign clear = reset | flush;
`else
    assign clear = reset;
`endif

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // The head reads as zero while empty so the outputs are defined right after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/completion sequencer around a fixed-latency multiplier core; MULT_FLUSH_EN adds flush recovery.
// mult_p is captured together with tag pipe stage LATENCY-1.
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TAG_W      = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mult_issue_ctrl_if.slave  bus,
    output logic [DATA_W-1:0] mult_a,
    output logic [DATA_W-1:0] mult_b,
    input  logic [DATA_W-1:0] mult_p
);

    localparam int CNT_W   = credit_w(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + TAG_W;

    logic               flush_now;
    logic               accept;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   credit_cnt;
    logic [LATENCY-1:0] pipe_vld;
    logic [TAG_W-1:0]   pipe_tag [LATENCY];
    logic [ENTRY_W-1:0] head;

`ifdef MULT_FLUSH_EN
    assign flush_now = bus.flush;
`else
    assign flush_now = 1'b0;
`endif

    // Credits cover every op in the core and in the FIFO, so the core never needs to stall.
    assign bus.issuemult_ready = (credit_cnt < CNT_W'(FIFO_DEPTH)) && !flush_now;
    assign accept              = bus.issuemult_enable & bus.issuemult_ready;
    assign pop                 = bus.cdb_valid & bus.cdb_grant & ~flush_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_a <= '0;
            mult_b <= '0;
        end else if (accept) begin
            mult_a <= bus.issuemult_rsdata;
            mult_b <= bus.issuemult_rtdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_vld[0] <= accept & ~flush_now;
            if (accept) pipe_tag[0] <= bus.issuemult_rdtag;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] & ~flush_now;
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_now) begin
            credit_cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credit_cnt <= credit_cnt + CNT_W'(1);
                2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    mult_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
`ifdef MULT_FLUSH_EN
        .flush     (flush_now),
`endif
        .push      (pipe_vld[LATENCY-1]),
        .push_data ({mult_p, pipe_tag[LATENCY-1]}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.cdb_valid = ~fifo_empty;
    assign bus.cdb_data  = head[ENTRY_W-1:TAG_W];
    assign bus.cdb_rdtag = head[TAG_W-1:0];

    // A completing op must always find room; the credit scheme makes this impossible to violate.
    assert property (@(posedge clk) disable iff (reset)
        !(pipe_vld[LATENCY-1] && fifo_full && !pop && !flush_now));

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl (LATENCY=4, FIFO_DEPTH=4); flush tests build with MULT_FLUSH_EN.
module tb_mult_issue_ctrl;
    import mult_ctrl_pkg::*;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  tag;
        logic [31:0] exp_p;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_p;
    logic [31:0] core_p [3];
    logic        flush_bit;

    int      errors = 0;
    int      checks = 0;
    result_t sb [$];
    vec_t    vecs [5];

    mult_issue_ctrl_if #(.DATA_W(32), .TAG_W(6)) bus ();

    mult_issue_ctrl #(
        .LATENCY    (4),
        .FIFO_DEPTH (4),
        .DATA_W     (32),
        .TAG_W      (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_p (mult_p)
    );

    always #5 clk = ~clk;

    // Core model: mult_a/mult_b form its first register stage, three more stages follow.
    always_ff @(posedge clk) begin
        core_p[0] <= mult_a * mult_b;
        core_p[1] <= core_p[0];
        core_p[2] <= core_p[1];
    end
    assign mult_p = core_p[2];

`ifdef MULT_FLUSH_EN
    assign flush_bit = bus.flush;
`else
    assign flush_bit = 1'b0;
`endif

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every pop the DUT performs is compared against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && !flush_bit && bus.cdb_valid && bus.cdb_grant) begin
            if (sb.size() == 0) begin
                check_output("unexpected_result", 64'({bus.cdb_data, bus.cdb_rdtag}), 64'(0));
            end else begin
                result_t e;
                e = sb.pop_front();
                check_output("cdb_result", 64'({bus.cdb_data, bus.cdb_rdtag}), 64'({e.data, e.tag}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] t,
                                  input logic [31:0] expp, output int waited);
        result_t e;
        bus.issuemult_enable = 1'b1;
        bus.issuemult_rsdata = a;
        bus.issuemult_rtdata = b;
        bus.issuemult_rdtag  = t;
        waited = 0;
        @(negedge clk);
        while (!bus.issuemult_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.issuemult_ready) begin
            e.data = expp;
            e.tag  = t;
            sb.push_back(e);
        end else begin
            check_output("accept_timeout", 64'(bus.issuemult_ready), 64'(1));
        end
        tick();
        bus.issuemult_enable = 1'b0;
    endtask

    // Called right after the accepting edge; the result must appear exactly exp_cycles later.
    task automatic measure_latency(input int exp_cycles);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cdb_valid && k < 20);
        check_output("latency", 64'(k), 64'(exp_cycles));
        @(negedge clk);
        check_output("valid_after_pop", 64'(bus.cdb_valid), 64'(0));
        tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("drain", 64'(sb.size()), 64'(0));
        tick();
    endtask

    initial begin
        int w;
        int seen;
        result_t e;

        vecs[0] = '{32'd7,          32'd6,          6'h15, 32'd42};
        vecs[1] = '{32'hFFFF_FFFF,  32'd2,          6'h3F, 32'hFFFF_FFFE};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,  6'h01, 32'h0000_0000};
        vecs[3] = '{32'd1234,       32'd1000,       6'h2A, 32'd1234000};
        vecs[4] = '{32'h8000_0000,  32'd3,          6'h00, 32'h8000_0000};

        reset = 1'b1;
        bus.issuemult_enable = 1'b0;
        bus.issuemult_rsdata = '0;
        bus.issuemult_rtdata = '0;
        bus.issuemult_rdtag  = '0;
        bus.cdb_grant        = 1'b0;
`ifdef MULT_FLUSH_EN
        bus.flush            = 1'b0;
`endif
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check_output("reset_ready",  64'(bus.issuemult_ready), 64'(1));
        check_output("reset_valid",  64'(bus.cdb_valid),       64'(0));
        check_output("reset_mult_a", 64'(mult_a),              64'(0));
        check_output("reset_data",   64'({bus.cdb_data, bus.cdb_rdtag}), 64'(0));
        tick();

        $display("[TB] single ops with grant held");
        bus.cdb_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].rs, vecs[i].rt, vecs[i].tag, vecs[i].exp_p, w);
            check_output("single_accept_wait", 64'(w), 64'(0));
            measure_latency(5);
        end
        @(negedge clk);
        check_output("credits_returned_ready", 64'(bus.issuemult_ready), 64'(1));
        tick();

        $display("[TB] back-to-back fill");
        bus.cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(32'(i + 2), 32'(i + 11), 6'(i + 8), prod(32'(i + 2), 32'(i + 11)), w);
            check_output("fill_accept_wait", 64'(w), 64'(0));
        end
        bus.issuemult_enable = 1'b1;
        bus.issuemult_rsdata = 32'd100;
        bus.issuemult_rtdata = 32'd9;
        bus.issuemult_rdtag  = 6'h20;
        @(negedge clk);
        check_output("fill_full_ready", 64'(bus.issuemult_ready), 64'(0));
        repeat (8) tick();
        @(negedge clk);
        check_output("fill_still_blocked", 64'(bus.issuemult_ready), 64'(0));
        check_output("fill_head", 64'({bus.cdb_valid, bus.cdb_data, bus.cdb_rdtag}),
                     64'({1'b1, 32'd22, 6'd8}));
        tick();
        bus.cdb_grant = 1'b1;
        apply_stimulus(32'd100, 32'd9, 6'h20, 32'd900, w);
        check_output("fifth_wait", 64'(w), 64'(1));
        wait_drain();
        bus.cdb_grant = 1'b0;

        $display("[TB] cdb stall");
        apply_stimulus(32'h0000_1234, 32'h0000_0100, 6'h0A, 32'h0012_3400, w);
        seen = 0;
        while (!bus.cdb_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("stall_hold", 64'({bus.cdb_valid, bus.cdb_data, bus.cdb_rdtag}),
                         64'({1'b1, 32'h0012_3400, 6'h0A}));
        end
        tick();
        bus.cdb_grant = 1'b1;
        tick();
        bus.cdb_grant = 1'b0;
        @(negedge clk);
        check_output("stall_single_pop", 64'(bus.cdb_valid), 64'(0));
        tick();

        $display("[TB] accept and pop together");
        for (int i = 0; i < 4; i++)
            apply_stimulus(32'(i + 20), 32'd3, 6'(i + 40), prod(32'(i + 20), 32'd3), w);
        repeat (8) tick();
        bus.issuemult_enable = 1'b1;
        bus.issuemult_rsdata = 32'd50;
        bus.issuemult_rtdata = 32'd4;
        bus.issuemult_rdtag  = 6'h31;
        bus.cdb_grant        = 1'b1;
        @(negedge clk);
        check_output("full_pop_ready", 64'(bus.issuemult_ready), 64'(0));
        tick();
        @(negedge clk);
        check_output("after_pop_ready", 64'(bus.issuemult_ready), 64'(1));
        e.data = 32'd200;
        e.tag  = 6'h31;
        sb.push_back(e);
        tick();
        bus.issuemult_enable = 1'b0;
        bus.cdb_grant        = 1'b0;
        @(negedge clk);
        check_output("acc_pop_ready", 64'(bus.issuemult_ready), 64'(1));
        tick();
        apply_stimulus(32'd60, 32'd5, 6'h32, 32'd300, w);
        check_output("acc_pop_accept_wait", 64'(w), 64'(0));
        @(negedge clk);
        check_output("count_stays_3", 64'(bus.issuemult_ready), 64'(0));
        tick();
        bus.cdb_grant = 1'b1;
        wait_drain();
        bus.cdb_grant = 1'b0;

        $display("[TB] reset mid-flight");
        apply_stimulus(32'd2, 32'd3, 6'h11, 32'd6, w);
        repeat (5) tick();
        apply_stimulus(32'd4, 32'd3, 6'h12, 32'd12, w);
        apply_stimulus(32'd5, 32'd3, 6'h13, 32'd15, w);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_output("post_reset_ready", 64'(bus.issuemult_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.cdb_valid) seen++;
        end
        check_output("post_reset_no_valid", 64'(seen), 64'(0));
        tick();
        bus.cdb_grant = 1'b1;
        apply_stimulus(32'd3, 32'd5, 6'h33, 32'd15, w);
        measure_latency(5);
        bus.cdb_grant = 1'b0;

`ifdef MULT_FLUSH_EN
        $display("[TB] flush");
        apply_stimulus(32'd7, 32'd7, 6'h01, 32'd49, w);
        apply_stimulus(32'd8, 32'd8, 6'h02, 32'd64, w);
        repeat (3) tick();
        apply_stimulus(32'd9, 32'd9, 6'h03, 32'd81, w);
        apply_stimulus(32'd10, 32'd10, 6'h04, 32'd100, w);
        bus.flush            = 1'b1;
        bus.issuemult_enable = 1'b1;
        bus.issuemult_rsdata = 32'd11;
        bus.issuemult_rtdata = 32'd11;
        bus.issuemult_rdtag  = 6'h05;
        bus.cdb_grant        = 1'b1;
        @(negedge clk);
        check_output("flush_ready", 64'(bus.issuemult_ready), 64'(0));
        tick();
        bus.flush            = 1'b0;
        bus.issuemult_enable = 1'b0;
        bus.cdb_grant        = 1'b0;
        sb.delete();
        @(negedge clk);
        check_output("flush_valid_next", 64'(bus.cdb_valid), 64'(0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cdb_valid) seen++;
        end
        check_output("flush_no_results", 64'(seen), 64'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(32'(i + 30), 32'd2, 6'(i + 50), prod(32'(i + 30), 32'd2), w);
            check_output("flush_credit_free", 64'(w), 64'(0));
        end
        @(negedge clk);
        check_output("flush_refill_full", 64'(bus.issuemult_ready), 64'(0));
        tick();
        bus.cdb_grant = 1'b1;
        wait_drain();
        bus.cdb_grant = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
